// File: rtl/aoi_pkg.sv
// Shared types and default geometry for param_aoi_unit.
package aoi_pkg;
    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2,
        FLUSH = 2'd3
    } aoi_state_e;

    // Default geometry reproduces the 4-input AOI ~((a&b)|(c&d))
    localparam int GROUPS_DEF = 2;
    localparam int GW_DEF     = 2;
endpackage

// File: rtl/param_aoi_unit_if.sv
// Operand/result handshake bundle for param_aoi_unit.
interface param_aoi_unit_if #(
    parameter int N = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_data;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Unit side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aoi_and_group.sv
// One GW-input AND term feeding the first pipeline stage.
module aoi_and_group #(
    parameter int GW = 2
) (
    input  logic [GW-1:0] a,
    output logic          y
);
    assign y = &a;
endmodule

// File: rtl/param_aoi_unit.sv
// Parameterised AND-OR-INVERT unit: 2-stage valid/ready pipeline computing
// ~(OR over groups of AND(group)). With AOI_SWEEP_EN defined, a controller
// can sweep all 2^N input vectors through the same pipeline and count the
// results that are 1. Without AOI_SWEEP_EN the unit is evaluation-only.
module param_aoi_unit
    import aoi_pkg::*;
#(
    parameter int GROUPS = GROUPS_DEF,
    parameter int GW     = GW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    param_aoi_unit_if.slave      bus,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [GROUPS*GW:0]   ones_count
);
    localparam int N = GROUPS * GW;

    // Sweep-controller hooks into the datapath
    logic         sweep_inj;  // inject sweep_vec into S1 this cycle
    logic [N-1:0] sweep_vec;
    logic         idle_ok;    // controller allows external vectors

    // Pipeline state; *_swp marks entries that belong to a sweep
    logic              s1_vld_q, s1_vld_d, s1_swp_q, s1_swp_d;
    logic [GROUPS-1:0] s1_and_q, s1_and_d;
    logic              s2_vld_q, s2_vld_d, s2_swp_q, s2_swp_d;
    logic              s2_data_q, s2_data_d;

    logic              adv, accept;
    logic [N-1:0]      s1_src;
    logic [GROUPS-1:0] and_terms;

    // Sweep results never stall: they are counted, not presented downstream
    assign adv          = !s2_vld_q || s2_swp_q || bus.out_ready;
    assign bus.in_ready = adv && idle_ok;
    assign accept       = bus.in_valid && bus.in_ready;
    assign s1_src       = sweep_inj ? sweep_vec : bus.in_data;

    assign bus.out_valid = s2_vld_q && !s2_swp_q;
    assign bus.out_data  = s2_data_q;

    for (genvar g = 0; g < GROUPS; g++) begin : g_and
        aoi_and_group #(.GW(GW)) u_and (
            .a (s1_src[g*GW +: GW]),
            .y (and_terms[g])
        );
    end

    // Pipeline next state: load both stages together when adv, else hold
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_swp_d  = s1_swp_q;
        s1_and_d  = s1_and_q;
        s2_vld_d  = s2_vld_q;
        s2_swp_d  = s2_swp_q;
        s2_data_d = s2_data_q;
        if (adv) begin
            s1_vld_d = accept || sweep_inj;
            s1_swp_d = sweep_inj;
            s1_and_d = and_terms;
            s2_vld_d = s1_vld_q;
            s2_swp_d = s1_swp_q;
            if (s1_vld_q) s2_data_d = ~|s1_and_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_swp_q  <= 1'b0;
            s1_and_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_swp_q  <= 1'b0;
            s2_data_q <= 1'b1;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_swp_q  <= s1_swp_d;
            s1_and_q  <= s1_and_d;
            s2_vld_q  <= s2_vld_d;
            s2_swp_q  <= s2_swp_d;
            s2_data_q <= s2_data_d;
        end
    end

`ifdef AOI_SWEEP_EN
    aoi_state_e   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N:0]   ones_q, ones_d;
    logic         done_q, done_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: drain pending work, sweep, then wait for the tail
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRAIN;
            DRAIN:   if (!s1_vld_q && !s2_vld_q) state_d = SWEEP;
            SWEEP:   if (&cnt_q) state_d = FLUSH;
            // Last vector sits alone in S2 and is counted on this edge
            FLUSH:   if (!s1_vld_q && s2_vld_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs plus counter/tally next values
    always_comb begin
        busy      = (state_q != IDLE);
        sweep_inj = (state_q == SWEEP);
        idle_ok   = (state_q == IDLE) && !start;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        done_d    = 1'b0;
        if (state_q == DRAIN && state_d == SWEEP) begin
            cnt_d  = '0;
            ones_d = '0;
        end
        if (state_q == SWEEP && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
        if (s2_vld_q && s2_swp_q && s2_data_q) ones_d = ones_q + 1'b1;
        if (state_q == FLUSH && state_d == IDLE) done_d = 1'b1;
    end

    // Sweep counter, ones tally and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            ones_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
            done_q <= done_d;
        end
    end

    assign sweep_vec  = cnt_q;
    assign done       = done_q;
    assign ones_count = ones_q;
`else
    logic unused_start;

    assign unused_start = start;
    assign sweep_inj    = 1'b0;
    assign sweep_vec    = '0;
    assign idle_ok      = 1'b1;
    assign busy         = 1'b0;
    assign done         = 1'b0;
    assign ones_count   = '0;
`endif

endmodule

// File: doc/param_aoi_unit.md
PARAM_AOI_UNIT -- requirements
Module: param_aoi_unit

Interface
REQ-001 The block SHALL have parameter GROUPS, default 2, giving the number of AND groups (range 1..8).
REQ-002 The block SHALL have parameter GW, default 2, giving the inputs per AND group (range 1..4); N = GROUPS*GW, and the default reproduces the 4-input AOI e = ~((a&b)|(c&d)).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an input vector is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the vector this cycle.
REQ-007 The block SHALL have port in_data, input, N, the operand vector; bits [g*GW+GW-1:g*GW] form group g.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-010 The block SHALL have port out_data, output, 1, the AOI result ~(OR over g of AND(group g)).
REQ-011 The block SHALL have port start, input, 1, a one-cycle request to start an exhaustive sweep.
REQ-012 The block SHALL have port busy, output, 1, high while a sweep is active.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-014 The block SHALL have port ones_count, output, N+1, the number of sweep vectors giving out_data=1.

Function
REQ-015 The evaluation path SHALL be a 2-stage pipeline: S1 registers the GROUPS AND terms; S2 registers the inverted OR; latency is 2 cycles from in_valid&&in_ready to out_valid.
REQ-016 The pipeline SHALL advance when adv = !S2_valid || out_ready; when adv=0, S1 and S2 hold their contents.
REQ-017 in_ready SHALL equal adv && (state==IDLE) && !start.
REQ-018 out_valid and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 The FSM SHALL have the states IDLE, DRAIN, SWEEP and FLUSH.
REQ-020 IDLE -> DRAIN SHALL occur on start=1; DRAIN -> SWEEP SHALL occur once S1 and S2 are empty; SWEEP -> FLUSH SHALL occur after vector 2^N-1 is injected; FLUSH -> IDLE SHALL occur after the last result is counted.
REQ-021 On entry to SWEEP, ones_count SHALL clear to 0 and the N-bit sweep counter SHALL load 0.
REQ-022 In SWEEP, the counter value SHALL be injected into S1 every cycle and increment by 1, stopping at 2^N-1 without wrapping.
REQ-023 Sweep results SHALL increment ones_count when out_data=1, SHALL keep out_valid=0, and SHALL ignore out_ready.
REQ-024 done SHALL pulse for exactly one cycle on the FLUSH -> IDLE edge; ones_count SHALL then hold until the next SWEEP entry.
REQ-025 busy SHALL be 1 in DRAIN, SWEEP and FLUSH.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 When start and in_valid are both high in IDLE, start SHALL win and the vector SHALL not be accepted.

Reset
REQ-028 On rst=1 at a clock edge, the FSM SHALL go to IDLE, S1/S2 valid bits and out_valid SHALL go to 0, out_data to 1, ones_count to 0, done to 0, busy to 0, and the sweep counter to 0.
REQ-029 A reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro AOI_SWEEP_EN defined SHALL compile in the FSM, sweep counter, ones_count, busy and done.
REQ-032 Without AOI_SWEEP_EN, start SHALL be ignored, busy/done/ones_count SHALL tie to 0, state SHALL remain IDLE permanently, and evaluation SHALL be unchanged.

Structure
REQ-033 Package aoi_pkg SHALL hold the FSM state typedef (IDLE, DRAIN, SWEEP, FLUSH) and the GROUPS/GW default constants.
REQ-034 Sub-module aoi_and_group (GW-input AND, combinational) SHALL be instantiated GROUPS times ahead of S1.

Verification (defaults GROUPS=2, GW=2)
REQ-035 The bench SHALL check: in_data=4'b0011 with out_ready=1 -> out_data=0, out_valid exactly 2 cycles after acceptance.
REQ-036 The bench SHALL check: all 16 vectors streamed with out_ready=1 -> outputs match ~((a&b)|(c&d)) in order, one per cycle.
REQ-037 The bench SHALL check: out_ready=0 for 5 cycles with a result held -> out_data stable, in_ready=0 once S1 is full, no result lost.
REQ-038 The bench SHALL check: start from empty IDLE -> busy=1, a single done pulse, ones_count=9, out_valid=0 throughout.
REQ-039 The bench SHALL check: rst=1 for 1 cycle at sweep vector 7 -> next cycle busy=0, ones_count=0, and no done pulse.
REQ-040 The bench SHALL check: start and in_valid in the same IDLE cycle -> in_ready=0 and the sweep runs; build without AOI_SWEEP_EN -> busy never rises.
